ifu: RTL and testbench

- Instruction fetch unit: owns the PC and issues fetch requests on an SRAM-style valid/ready port.
- Returns {inst_id, pc_id} to the decode stage over a valid/ready handshake.
- Accepts control-flow redirects (jumps/branches) from downstream and discards stale in-flight fetches.
- Sits between instruction memory and idu; one instruction in flight, no prefetch buffer.

---
 rtl/ifu.sv | 115 +++++++++++
 tb/tb_ifu.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifu.sv
// Instruction fetch unit: owns the PC, issues one fetch at a time on a valid/ready
// memory port and hands {inst_id, pc_id} to decode, squashing fetches made stale by redirects.
module ifu #(
  parameter int                INST_W   = 32,
  parameter logic [INST_W-1:0] RESET_PC = 32'h8000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              redirect_valid,
  input  logic [INST_W-1:0] redirect_pc,
  output logic              ifu_req_valid,
  input  logic              ifu_req_ready,
  output logic [INST_W-1:0] ifu_req_addr,
  input  logic              ifu_rsp_valid,
  output logic              ifu_rsp_ready,
  input  logic [INST_W-1:0] ifu_rsp_data,
  input  logic              ifu_rsp_err,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [INST_W-1:0] inst_id,
  output logic [INST_W-1:0] pc_id,
  output logic              inst_fault
);

  // state | meaning
  // IDLE  | one cycle after reset, nothing asserted
  // REQ   | fetch request for pc offered to memory
  // WAIT  | request accepted, waiting for response (drop marks it stale)
  // VALID | instruction presented to decode, held until consumed or squashed
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_WAIT  = 2'd2,
    S_VALID = 2'd3
  } state_t;

  state_t            state;
  logic [INST_W-1:0] pc;
  logic              drop;

  // Address is sampled by memory only on handshake, so it may track pc freely.
  assign ifu_req_addr = pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      pc            <= RESET_PC;
      drop          <= 1'b0;
      ifu_req_valid <= 1'b0;
      ifu_rsp_ready <= 1'b0;
      inst_valid    <= 1'b0;
      inst_id       <= '0;
      pc_id         <= RESET_PC;
      inst_fault    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          state         <= S_REQ;
          ifu_req_valid <= 1'b1;
        end

        S_REQ: begin
          if (redirect_valid) pc <= redirect_pc;
          if (ifu_req_valid && ifu_req_ready) begin
            state         <= S_WAIT;
            ifu_req_valid <= 1'b0;
            ifu_rsp_ready <= 1'b1;
            // The accepted request carries the old pc; its data must be thrown away.
            drop          <= redirect_valid;
          end
        end

        S_WAIT: begin
          if (ifu_rsp_valid) begin
            ifu_rsp_ready <= 1'b0;
            drop          <= 1'b0;
            if (redirect_valid || drop) begin
              state         <= S_REQ;
              ifu_req_valid <= 1'b1;
              if (redirect_valid) pc <= redirect_pc;
            end else begin
              state      <= S_VALID;
              inst_valid <= 1'b1;
              inst_id    <= ifu_rsp_err ? '0 : ifu_rsp_data;
              pc_id      <= pc;
              inst_fault <= ifu_rsp_err;
            end
          end else if (redirect_valid) begin
            pc   <= redirect_pc;
            drop <= 1'b1;
          end
        end

        S_VALID: begin
          if (redirect_valid || inst_ready) begin
            pc            <= redirect_valid ? redirect_pc : pc + INST_W'(4);
            inst_valid    <= 1'b0;
            state         <= S_REQ;
            ifu_req_valid <= 1'b1;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

  // Decode relies on the presented instruction not changing while it stalls.
  property p_inst_hold;
    @(posedge clk) disable iff (rst)
      (inst_valid && !inst_ready) |=> ($stable(inst_id) && $stable(pc_id) && $stable(inst_fault));
  endproperty
  a_inst_hold: assert property (p_inst_hold);

endmodule

// File: tb/tb_ifu.sv
// Directed bench for ifu: bench acts as instruction memory and decode stage,
// driving and sampling on the falling clock edge.
module tb_ifu;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        ifu_req_valid;
  logic        ifu_req_ready;
  logic [31:0] ifu_req_addr;
  logic        ifu_rsp_valid;
  logic        ifu_rsp_ready;
  logic [31:0] ifu_rsp_data;
  logic        ifu_rsp_err;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_id;
  logic [31:0] pc_id;
  logic        inst_fault;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ifu dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .ifu_req_valid  (ifu_req_valid),
    .ifu_req_ready  (ifu_req_ready),
    .ifu_req_addr   (ifu_req_addr),
    .ifu_rsp_valid  (ifu_rsp_valid),
    .ifu_rsp_ready  (ifu_rsp_ready),
    .ifu_rsp_data   (ifu_rsp_data),
    .ifu_rsp_err    (ifu_rsp_err),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_id        (inst_id),
    .pc_id          (pc_id),
    .inst_fault     (inst_fault)
  );

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Waits (bounded) for a fetch request; returns whether one appeared and its address.
  task automatic wait_req(output logic ok, output logic [31:0] addr);
    ok   = 1'b0;
    addr = '0;
    for (int i = 0; i < 10; i++) begin
      if (ifu_req_valid) begin
        ok   = 1'b1;
        addr = ifu_req_addr;
        break;
      end
      tick();
    end
  endtask

  task automatic accept_req();
    ifu_req_ready = 1'b1;
    tick();
    ifu_req_ready = 1'b0;
  endtask

  task automatic give_rsp(input logic [31:0] data, input logic err);
    ifu_rsp_valid = 1'b1;
    ifu_rsp_data  = data;
    ifu_rsp_err   = err;
    tick();
    ifu_rsp_valid = 1'b0;
    ifu_rsp_data  = '0;
    ifu_rsp_err   = 1'b0;
  endtask

  task automatic consume();
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if (ifu_req_valid !== 1'b0 || ifu_rsp_ready !== 1'b0 || inst_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_valids: req_valid=%b rsp_ready=%b inst_valid=%b, required 0 0 0",
               ifu_req_valid, ifu_rsp_ready, inst_valid);
    end
    checks++;
    if (inst_id !== 32'h0 || pc_id !== 32'h8000_0000 || inst_fault !== 1'b0) begin
      failures++;
      $display("FAIL reset_regs: inst_id=%h pc_id=%h fault=%b, required 00000000 80000000 0",
               inst_id, pc_id, inst_fault);
    end
    checks++;
    if (ifu_req_addr !== 32'h8000_0000) begin
      failures++;
      $display("FAIL reset_addr: got %h required 80000000", ifu_req_addr);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (ifu_req_valid !== 1'b1) begin
      failures++;
      $display("FAIL first_req_after_idle: req_valid=%b required 1", ifu_req_valid);
    end
  endtask

  task automatic test_sequential();
    logic        ok;
    logic [31:0] addr;
    logic [31:0] exp_pc;
    for (int k = 0; k < 3; k++) begin
      exp_pc = 32'h8000_0000 + 32'(4 * k);
      wait_req(ok, addr);
      checks++;
      if (!ok || addr !== exp_pc) begin
        failures++;
        $display("FAIL seq_addr[%0d]: ok=%b addr=%h required %h", k, ok, addr, exp_pc);
      end
      accept_req();
      checks++;
      if (ifu_req_valid !== 1'b0 || ifu_rsp_ready !== 1'b1 || inst_valid !== 1'b0) begin
        failures++;
        $display("FAIL seq_wait[%0d]: req_valid=%b rsp_ready=%b inst_valid=%b required 0 1 0",
                 k, ifu_req_valid, ifu_rsp_ready, inst_valid);
      end
      give_rsp(32'h0000_1000 + 32'(k), 1'b0);
      checks++;
      if (inst_valid !== 1'b1 || pc_id !== exp_pc || inst_id !== 32'h0000_1000 + 32'(k)
          || inst_fault !== 1'b0) begin
        failures++;
        $display("FAIL seq_inst[%0d]: valid=%b pc_id=%h inst=%h fault=%b required 1 %h %h 0",
                 k, inst_valid, pc_id, inst_id, inst_fault, exp_pc, 32'h0000_1000 + 32'(k));
      end
      consume();
    end
  endtask

  task automatic test_stall();
    logic        ok;
    logic [31:0] addr;
    wait_req(ok, addr);
    checks++;
    if (!ok || addr !== 32'h8000_000C) begin
      failures++;
      $display("FAIL stall_addr: ok=%b addr=%h required 8000000c", ok, addr);
    end
    accept_req();
    give_rsp(32'h0010_0093, 1'b0);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (inst_valid !== 1'b1 || inst_id !== 32'h0010_0093 || pc_id !== 32'h8000_000C
          || ifu_req_valid !== 1'b0) begin
        failures++;
        $display("FAIL stall_hold[%0d]: valid=%b inst=%h pc_id=%h req_valid=%b required 1 00100093 8000000c 0",
                 i, inst_valid, inst_id, pc_id, ifu_req_valid);
      end
      tick();
    end
    consume();
    checks++;
    if (inst_valid !== 1'b0 || ifu_req_valid !== 1'b1 || ifu_req_addr !== 32'h8000_0010) begin
      failures++;
      $display("FAIL stall_next: valid=%b req_valid=%b addr=%h required 0 1 80000010",
               inst_valid, ifu_req_valid, ifu_req_addr);
    end
  endtask

  task automatic test_fault();
    logic        ok;
    logic [31:0] addr;
    wait_req(ok, addr);
    accept_req();
    give_rsp(32'hFFFF_FFFF, 1'b1);
    checks++;
    if (inst_valid !== 1'b1 || inst_fault !== 1'b1 || inst_id !== 32'h0 || pc_id !== 32'h8000_0010) begin
      failures++;
      $display("FAIL fault_inst: valid=%b fault=%b inst=%h pc_id=%h required 1 1 00000000 80000010",
               inst_valid, inst_fault, inst_id, pc_id);
    end
    consume();
    wait_req(ok, addr);
    checks++;
    if (!ok || addr !== 32'h8000_0014) begin
      failures++;
      $display("FAIL fault_next: ok=%b addr=%h required 80000014", ok, addr);
    end
  endtask

  task automatic test_redirect_wait();
    logic        ok;
    logic [31:0] addr;
    logic        saw_stale = 1'b0;
    accept_req();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0100;
    tick();
    redirect_valid = 1'b0;
    checks++;
    if (ifu_rsp_ready !== 1'b1 || inst_valid !== 1'b0) begin
      failures++;
      $display("FAIL rdw_still_wait: rsp_ready=%b valid=%b required 1 0", ifu_rsp_ready, inst_valid);
    end
    give_rsp(32'hDEAD_BEEF, 1'b0);
    for (int i = 0; i < 3; i++) begin
      if (inst_valid === 1'b1) saw_stale = 1'b1;
      tick();
    end
    checks++;
    if (saw_stale !== 1'b0) begin
      failures++;
      $display("FAIL rdw_stale: stale instruction shown=%b required 0", saw_stale);
    end
    wait_req(ok, addr);
    checks++;
    if (!ok || addr !== 32'h8000_0100) begin
      failures++;
      $display("FAIL rdw_addr: ok=%b addr=%h required 80000100", ok, addr);
    end
    accept_req();
    give_rsp(32'h0000_0013, 1'b0);
    checks++;
    if (inst_valid !== 1'b1 || pc_id !== 32'h8000_0100 || inst_id !== 32'h0000_0013) begin
      failures++;
      $display("FAIL rdw_inst: valid=%b pc_id=%h inst=%h required 1 80000100 00000013",
               inst_valid, pc_id, inst_id);
    end
    consume();
  endtask

  task automatic test_redirect_rsp();
    logic        ok;
    logic [31:0] addr;
    wait_req(ok, addr);
    checks++;
    if (!ok || addr !== 32'h8000_0104) begin
      failures++;
      $display("FAIL rdr_start: ok=%b addr=%h required 80000104", ok, addr);
    end
    accept_req();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0200;
    give_rsp(32'hCAFE_F00D, 1'b0);
    redirect_valid = 1'b0;
    checks++;
    if (inst_valid !== 1'b0 || ifu_req_valid !== 1'b1 || ifu_req_addr !== 32'h8000_0200) begin
      failures++;
      $display("FAIL rdr_discard: valid=%b req_valid=%b addr=%h required 0 1 80000200",
               inst_valid, ifu_req_valid, ifu_req_addr);
    end
    accept_req();
    give_rsp(32'h0000_0011, 1'b0);
    checks++;
    if (inst_valid !== 1'b1 || pc_id !== 32'h8000_0200 || inst_id !== 32'h0000_0011) begin
      failures++;
      $display("FAIL rdr_inst: valid=%b pc_id=%h inst=%h required 1 80000200 00000011",
               inst_valid, pc_id, inst_id);
    end
    consume();
  endtask

  task automatic test_redirect_handshake();
    ifu_req_ready  = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0300;
    tick();
    ifu_req_ready  = 1'b0;
    redirect_valid = 1'b0;
    checks++;
    if (ifu_rsp_ready !== 1'b1 || ifu_req_addr !== 32'h8000_0300) begin
      failures++;
      $display("FAIL rdh_wait: rsp_ready=%b addr=%h required 1 80000300", ifu_rsp_ready, ifu_req_addr);
    end
    give_rsp(32'hBAD0_0001, 1'b0);
    checks++;
    if (inst_valid !== 1'b0 || ifu_req_valid !== 1'b1 || ifu_req_addr !== 32'h8000_0300) begin
      failures++;
      $display("FAIL rdh_drop: valid=%b req_valid=%b addr=%h required 0 1 80000300",
               inst_valid, ifu_req_valid, ifu_req_addr);
    end
    accept_req();
    give_rsp(32'h0000_0022, 1'b0);
    checks++;
    if (inst_valid !== 1'b1 || pc_id !== 32'h8000_0300 || inst_id !== 32'h0000_0022) begin
      failures++;
      $display("FAIL rdh_inst: valid=%b pc_id=%h inst=%h required 1 80000300 00000022",
               inst_valid, pc_id, inst_id);
    end
    consume();
    // Redirect while the request is still unaccepted just retargets it.
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0400;
    tick();
    redirect_valid = 1'b0;
    checks++;
    if (ifu_req_valid !== 1'b1 || ifu_req_addr !== 32'h8000_0400 || ifu_rsp_ready !== 1'b0) begin
      failures++;
      $display("FAIL rdh_req_retarget: req_valid=%b addr=%h rsp_ready=%b required 1 80000400 0",
               ifu_req_valid, ifu_req_addr, ifu_rsp_ready);
    end
  endtask

  task automatic test_wrap();
    logic        ok;
    logic [31:0] addr;
    accept_req();
    give_rsp(32'h0000_0033, 1'b0);
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    checks++;
    if (inst_valid !== 1'b0 || ifu_req_valid !== 1'b1 || ifu_req_addr !== 32'hFFFF_FFFC) begin
      failures++;
      $display("FAIL wrap_squash: valid=%b req_valid=%b addr=%h required 0 1 fffffffc",
               inst_valid, ifu_req_valid, ifu_req_addr);
    end
    accept_req();
    give_rsp(32'h0000_0044, 1'b0);
    checks++;
    if (inst_valid !== 1'b1 || pc_id !== 32'hFFFF_FFFC || inst_id !== 32'h0000_0044) begin
      failures++;
      $display("FAIL wrap_inst: valid=%b pc_id=%h inst=%h required 1 fffffffc 00000044",
               inst_valid, pc_id, inst_id);
    end
    consume();
    wait_req(ok, addr);
    checks++;
    if (!ok || addr !== 32'h0000_0000) begin
      failures++;
      $display("FAIL wrap_addr: ok=%b addr=%h required 00000000", ok, addr);
    end
  endtask

  task automatic test_reset_mid();
    accept_req();
    rst = 1'b1;
    #1;
    checks++;
    if (ifu_rsp_ready !== 1'b0 || ifu_req_valid !== 1'b0 || ifu_req_addr !== 32'h8000_0000) begin
      failures++;
      $display("FAIL rst_mid_async: rsp_ready=%b req_valid=%b addr=%h required 0 0 80000000",
               ifu_rsp_ready, ifu_req_valid, ifu_req_addr);
    end
    @(negedge clk);
    rst            = 1'b0;
    ifu_rsp_valid  = 1'b1;
    ifu_rsp_data   = 32'h5757_5757;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_1234;
    tick();
    ifu_rsp_valid  = 1'b0;
    ifu_rsp_data   = '0;
    redirect_valid = 1'b0;
    checks++;
    if (inst_valid !== 1'b0 || ifu_req_valid !== 1'b1 || ifu_req_addr !== 32'h8000_0000
        || ifu_rsp_ready !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid_stray: valid=%b req_valid=%b addr=%h rsp_ready=%b required 0 1 80000000 0",
               inst_valid, ifu_req_valid, ifu_req_addr, ifu_rsp_ready);
    end
    accept_req();
    give_rsp(32'h0000_0055, 1'b0);
    checks++;
    if (inst_valid !== 1'b1 || pc_id !== 32'h8000_0000 || inst_id !== 32'h0000_0055) begin
      failures++;
      $display("FAIL rst_mid_refetch: valid=%b pc_id=%h inst=%h required 1 80000000 00000055",
               inst_valid, pc_id, inst_id);
    end
    consume();
  endtask

  initial begin
    rst            = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    ifu_req_ready  = 1'b0;
    ifu_rsp_valid  = 1'b0;
    ifu_rsp_data   = '0;
    ifu_rsp_err    = 1'b0;
    inst_ready     = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    test_sequential();
    test_stall();
    test_fault();
    test_redirect_wait();
    test_redirect_rsp();
    test_redirect_handshake();
    test_wrap();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
